// File: rtl/yuv_pack_pkg.sv
// Shared definitions for the YUV stream packer.
// Data word layout is four BITS-wide fields; a FIFO entry is
// {eof, eol, sof, data}, with the flags stacked directly above the data.
package yuv_pack_pkg;

  localparam int unsigned BITS_DEFAULT = 8;
  localparam int unsigned FIELDS       = 4;

  function automatic int unsigned word_w(input int unsigned bits);
    return FIELDS * bits;
  endfunction

  localparam int unsigned WORD_W = word_w(BITS_DEFAULT);

  // Field positions in units of one component (offset = POS * BITS).
  localparam int unsigned Y0_POS = 0;
  localparam int unsigned U_POS  = 1;
  localparam int unsigned Y1_POS = 2;
  localparam int unsigned V_POS  = 3;

  // Flag positions relative to the top of the data word in a FIFO entry.
  localparam int unsigned SOF_POS = 0;
  localparam int unsigned EOL_POS = 1;
  localparam int unsigned EOF_POS = 2;
  localparam int unsigned FLAG_W  = 3;

  typedef enum logic {
    MODE_444 = 1'b0,
    MODE_422 = 1'b1
  } pack_mode_e;

  typedef enum logic {
    PH_EVEN = 1'b0,
    PH_ODD  = 1'b1
  } pair_phase_e;

endpackage

// File: rtl/yuv_pack_fifo.sv
// Synchronous first-word-fall-through FIFO.
// Ports: pclk/rst_n clock and async active-low reset; push/wdata write side
// (ignored when full unless a pop happens in the same cycle); pop/rdata read
// side (rdata shows the head entry whenever empty=0); full/empty status.
module yuv_pack_fifo #(
  parameter int unsigned DW    = 35,
  parameter int unsigned DEPTH = 16
) (
  input  logic          pclk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [DW-1:0] wdata,
  input  logic          pop,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_pop;
  logic          do_push;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop & ~empty;
  // A full FIFO can still take a word when the head leaves this cycle.
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge pclk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/yuv_stream_packer.sv
// Packs a YUV pixel stream into 4*BITS-wide words and buffers them.
// 4:2:2 mode merges two pixels into {V, Y1, U, Y0}; 4:4:4 mode emits
// {0, V, U, Y} per pixel. Words carry sof/eol/eof and leave through a
// valid/ready port backed by yuv_pack_fifo.
// Ports: pclk, rst_n (async, active-low); yuv422 mode select (latched on
// vsync rise); in_href/in_vsync/in_y/in_c/in_v pixel input; out_data,
// out_valid, out_ready, out_sof/out_eol/out_eof word output; overflow and
// short_line sticky flags, cleared by clr_flags.
module yuv_stream_packer
  import yuv_pack_pkg::*;
#(
  parameter int unsigned BITS       = 8,
  parameter int unsigned WIDTH      = 1280,
  parameter int unsigned HEIGHT     = 960,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic              pclk,
  input  logic              rst_n,
  input  logic              yuv422,
  input  logic              in_href,
  input  logic              in_vsync,
  input  logic [BITS-1:0]   in_y,
  input  logic [BITS-1:0]   in_c,
  input  logic [BITS-1:0]   in_v,
  output logic [4*BITS-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_sof,
  output logic              out_eol,
  output logic              out_eof,
  output logic              overflow,
  output logic              short_line,
  input  logic              clr_flags
);

  localparam int unsigned DW = word_w(BITS);
  localparam int unsigned EW = DW + FLAG_W;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam int unsigned RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  // Registered state
  logic          vsync_q, href_q, armed_q, sof_arm_q;
  pack_mode_e    mode_q;
  pair_phase_e   phase_q;
  logic [CW-1:0] col_q;
  logic [RW-1:0] row_q;
  logic [BITS-1:0] y0_q, u_q;
  logic          stg_vld_q;
  logic [EW-1:0] stg_q;
  logic          overflow_q, short_q;

  // Next state
  logic          armed_d, sof_arm_d;
  pack_mode_e    mode_d;
  pair_phase_e   phase_d;
  logic [CW-1:0] col_d;
  logic [RW-1:0] row_d;
  logic [BITS-1:0] y0_d, u_d;
  logic          stg_vld_d;
  logic [EW-1:0] stg_d;
  logic          overflow_d, short_d;

  logic          vs_rise, h_fall, pix, last_col, last_row;
  logic          short_set, overflow_set;
  logic [DW-1:0] word;
  logic          w_sof, w_eol, w_eof;

  logic [EW-1:0] head;
  logic          fifo_full, fifo_empty, pop;

  assign vs_rise  = in_vsync & ~vsync_q;
  assign h_fall   = armed_q & href_q & ~in_href & ~vs_rise;
  assign pix      = armed_q & in_href & ~vs_rise & (col_q < CW'(WIDTH));
  assign last_col = (col_q == CW'(WIDTH - 1));
  assign last_row = (row_q == RW'(HEIGHT - 1));

  always_comb begin
    armed_d   = armed_q;
    sof_arm_d = sof_arm_q;
    mode_d    = mode_q;
    phase_d   = phase_q;
    col_d     = col_q;
    row_d     = row_q;
    y0_d      = y0_q;
    u_d       = u_q;
    stg_vld_d = 1'b0;
    stg_d     = stg_q;
    short_set = 1'b0;
    word      = '0;
    w_sof     = 1'b0;
    w_eol     = 1'b0;
    w_eof     = 1'b0;

    if (vs_rise) begin
      armed_d   = 1'b1;
      sof_arm_d = 1'b1;
      mode_d    = yuv422 ? MODE_422 : MODE_444;
      phase_d   = PH_EVEN;
      col_d     = '0;
      row_d     = '0;
    end else if (pix) begin
      col_d = col_q + CW'(1);
      w_eol = last_col;
      w_eof = last_col & last_row;
      if (mode_q == MODE_444) begin
        stg_vld_d                   = 1'b1;
        word[Y0_POS*BITS +: BITS]   = in_y;
        word[U_POS*BITS  +: BITS]   = in_c;
        word[Y1_POS*BITS +: BITS]   = in_v;
      end else if (phase_q == PH_EVEN) begin
        y0_d    = in_y;
        u_d     = in_c;
        phase_d = PH_ODD;
      end else begin
        stg_vld_d                   = 1'b1;
        word[Y0_POS*BITS +: BITS]   = y0_q;
        word[U_POS*BITS  +: BITS]   = u_q;
        word[Y1_POS*BITS +: BITS]   = in_y;
        word[V_POS*BITS  +: BITS]   = in_c;
        phase_d                     = PH_EVEN;
      end
    end else if (h_fall) begin
      if (col_q != CW'(WIDTH)) begin
        short_set = 1'b1;
        // Flush a dangling 4:2:2 half-word as the line's last word.
        if (mode_q == MODE_422 && phase_q == PH_ODD) begin
          stg_vld_d                 = 1'b1;
          word[Y0_POS*BITS +: BITS] = y0_q;
          word[U_POS*BITS  +: BITS] = u_q;
          w_eol                     = 1'b1;
          w_eof                     = last_row;
        end
      end
      col_d   = '0;
      phase_d = PH_EVEN;
      if (!last_row) begin
        row_d = row_q + RW'(1);
      end
    end

    if (stg_vld_d) begin
      w_sof                = sof_arm_q;
      sof_arm_d            = 1'b0;
      stg_d                = '0;
      stg_d[DW-1:0]        = word;
      stg_d[DW + SOF_POS]  = w_sof;
      stg_d[DW + EOL_POS]  = w_eol;
      stg_d[DW + EOF_POS]  = w_eof;
    end
  end

  assign pop          = ~fifo_empty & out_ready;
  assign overflow_set = stg_vld_q & fifo_full & ~pop;

  always_comb begin
    overflow_d = overflow_q;
    short_d    = short_q;
    if (overflow_set) begin
      overflow_d = 1'b1;
    end else if (clr_flags) begin
      overflow_d = 1'b0;
    end
    if (short_set) begin
      short_d = 1'b1;
    end else if (clr_flags) begin
      short_d = 1'b0;
    end
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q    <= 1'b0;
      href_q     <= 1'b0;
      armed_q    <= 1'b0;
      sof_arm_q  <= 1'b0;
      mode_q     <= MODE_444;
      phase_q    <= PH_EVEN;
      col_q      <= '0;
      row_q      <= '0;
      y0_q       <= '0;
      u_q        <= '0;
      stg_vld_q  <= 1'b0;
      stg_q      <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      vsync_q    <= in_vsync;
      href_q     <= in_href;
      armed_q    <= armed_d;
      sof_arm_q  <= sof_arm_d;
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      col_q      <= col_d;
      row_q      <= row_d;
      y0_q       <= y0_d;
      u_q        <= u_d;
      stg_vld_q  <= stg_vld_d;
      stg_q      <= stg_d;
      overflow_q <= overflow_d;
      short_q    <= short_d;
    end
  end

  yuv_pack_fifo #(
    .DW    (EW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .pclk  (pclk),
    .rst_n (rst_n),
    .push  (stg_vld_q),
    .wdata (stg_q),
    .pop   (pop),
    .rdata (head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Head is gated so outputs read zero whenever nothing is offered.
  assign out_valid  = ~fifo_empty;
  assign out_data   = fifo_empty ? '0 : head[DW-1:0];
  assign out_sof    = ~fifo_empty & head[DW + SOF_POS];
  assign out_eol    = ~fifo_empty & head[DW + EOL_POS];
  assign out_eof    = ~fifo_empty & head[DW + EOF_POS];
  assign overflow   = overflow_q;
  assign short_line = short_q;

endmodule
